// File: rtl/store_align_unit.sv
// Store alignment unit: converts SB/SH/SW requests into one or two word-aligned,
// lane-enabled memory beats, with per-beat MEM_READY timeout and error reporting.
module store_align_unit #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int TIMEOUT_CYCLES   = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STORE_EN,
  input  logic [1:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] DATA_IN,
  input  logic        MEM_READY,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, FINISH} state_t;

  state_t      r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic        r_split, w_split_next;
  logic [31:0] r_hi_wdata, w_hi_wdata_next;
  logic [3:0]  r_hi_be, w_hi_be_next;
  logic        r_write, w_write_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [3:0]  r_be, w_be_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_error, w_error_next;

  logic [3:0]  w_mask;
  logic [31:0] w_data_masked;
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;
  logic        w_split;
  logic        w_illegal;
  logic        w_timeout;

  always_comb begin
    w_mask        = 4'b0000;
    w_data_masked = 32'h0;
    case (FUNCT3)
      2'b00: begin w_mask = 4'b0001; w_data_masked = {24'h0, DATA_IN[7:0]};  end
      2'b01: begin w_mask = 4'b0011; w_data_masked = {16'h0, DATA_IN[15:0]}; end
      2'b10: begin w_mask = 4'b1111; w_data_masked = DATA_IN;                end
      default: ;
    endcase
  end

  // Shifting into a double-width window yields both beats at once: the low
  // word is beat 1, anything spilling into the high word belongs to beat 2.
  assign w_be_wide   = {4'b0000, w_mask} << ADDRESS[1:0];
  assign w_data_wide = {32'h0, w_data_masked} << {ADDRESS[1:0], 3'b000};
  assign w_split     = |w_be_wide[7:4];
  assign w_illegal   = (FUNCT3 == 2'b11) || (w_split && (ALLOW_MISALIGNED == 0));
  assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !MEM_READY;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_split_next    = r_split;
    w_hi_wdata_next = r_hi_wdata;
    w_hi_be_next    = r_hi_be;
    w_write_next    = r_write;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_be_next       = r_be;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_error_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (STORE_EN) begin
          if (w_illegal) begin
            w_error_next = 1'b1;
          end else begin
            w_state_next    = BEAT1;
            w_write_next    = 1'b1;
            w_busy_next     = 1'b1;
            w_addr_next     = {ADDRESS[31:2], 2'b00};
            w_wdata_next    = w_data_wide[31:0];
            w_be_next       = w_be_wide[3:0];
            w_hi_wdata_next = w_data_wide[63:32];
            w_hi_be_next    = w_be_wide[7:4];
            w_split_next    = w_split;
            w_cnt_next      = '0;
          end
        end
      end
      BEAT1, BEAT2: begin
        if (MEM_READY) begin
          if (r_state == BEAT1 && r_split) begin
            w_state_next = BEAT2;
            w_addr_next  = r_addr + 32'd4;
            w_wdata_next = r_hi_wdata;
            w_be_next    = r_hi_be;
            w_cnt_next   = '0;
          end else begin
            w_state_next = FINISH;
            w_write_next = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_write_next = 1'b0;
          w_busy_next  = 1'b0;
          w_error_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      FINISH: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_split    <= 1'b0;
      r_hi_wdata <= 32'h0;
      r_hi_be    <= 4'b0000;
      r_write    <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_be       <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_split    <= w_split_next;
      r_hi_wdata <= w_hi_wdata_next;
      r_hi_be    <= w_hi_be_next;
      r_write    <= w_write_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_be       <= w_be_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
    end
  end

  assign MEM_WRITE   = r_write;
  assign MEM_ADDR    = r_addr;
  assign MEM_WDATA   = r_wdata;
  assign MEM_BYTE_EN = r_be;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign ERROR       = r_error;

endmodule
